// File: rtl/mpmc12_req_sequencer.sv
// Request sequencer for the MPMC12 DRAM port. It walks one FIFO head through
// setup, command/data issue, read response collection and the optional
// read-modify-write ALU pass, then pops the head. A per-state dwell counter
// doubles as the PRESET / ALU_WAIT length counter and the hang watchdog.
module mpmc12_req_sequencer #(
    parameter int MAX_STRIPS = 8,
    parameter int ALU_LAT    = 4,
    parameter int PRESET_CYC = 3,
    parameter int TO_CYCLES  = 1024,
    localparam int SW        = $clog2(MAX_STRIPS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          calib_complete,
    input  logic          rst_busy,
    input  logic          fifo_empty,
    input  logic          fifo_v,
    input  logic          req_cyc,
    input  logic          req_we,
    input  logic          req_rmw,
    input  logic [SW-1:0] num_strips,
    input  logic          app_rdy,
    input  logic          app_wdf_rdy,
    input  logic          rd_data_valid,
    input  logic          rmw_hit,
    output logic [3:0]    state,
    output logic          app_en,
    output logic          app_wdf_wren,
    output logic          fifo_rd,
    output logic [SW-1:0] req_strip_cnt,
    output logic [SW-1:0] resp_strip_cnt,
    output logic          timeout,
    output logic          busy
);

    localparam int TW = $clog2(TO_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYCLES - 1);
    localparam logic [TW-1:0] PRE_LAST = TW'(PRESET_CYC - 1);
    localparam logic [TW-1:0] ALU_LAST = TW'(ALU_LAT - 1);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        PRESET      = 4'd1,
        WRITE       = 4'd2,
        READ_CMD    = 4'd3,
        READ_WAIT   = 4'd4,
        ALU         = 4'd5,
        ALU_WAIT    = 4'd6,
        WRITE_TRAMP = 4'd7,
        DONE        = 4'd8
    } state_t;

    state_t          state_q;
    state_t          state_nxt;
    state_t          rd_target;
    logic [TW-1:0]   dwell_cnt;
    logic [SW-1:0]   n_eff;
    logic [SW-1:0]   resp_post;
    logic            last_req;
    logic            resp_inc;
    logic            issue;
    logic            to_hit;
    logic            cnt_clr;

    assign state = state_q;
    assign busy  = (state_q != IDLE);

    // Next-state and strip bookkeeping decode
    always_comb begin
        n_eff     = (num_strips == '0) ? SW'(1) : num_strips;
        last_req  = (req_strip_cnt == n_eff - SW'(1));
        // responses are accepted while commands are still going out
        resp_inc  = ((state_q == READ_CMD) || (state_q == READ_WAIT)) &&
                    rd_data_valid && (resp_strip_cnt < n_eff);
        resp_post = resp_strip_cnt + SW'(resp_inc);
        issue     = ((state_q == WRITE) && app_rdy && app_wdf_rdy) ||
                    ((state_q == READ_CMD) && app_rdy);
        rd_target = req_rmw ? ALU : DONE;
        // dwell counter saturates, so losing calibration defers the abort
        to_hit    = (state_q != IDLE) && (dwell_cnt == TO_LAST) && calib_complete;
        state_nxt = state_q;
        case (state_q)
            IDLE:        if (!fifo_empty && fifo_v && !rst_busy && calib_complete)
                             state_nxt = PRESET;
            PRESET:      if (dwell_cnt == PRE_LAST)
                             state_nxt = !req_cyc ? DONE : (req_we ? WRITE : READ_CMD);
            WRITE:       if (issue && last_req)
                             state_nxt = DONE;
            READ_CMD:    if (issue && last_req)
                             state_nxt = (resp_post == n_eff) ? rd_target : READ_WAIT;
            READ_WAIT:   if (resp_post == n_eff)
                             state_nxt = rd_target;
            ALU:         if (rmw_hit)
                             state_nxt = ALU_WAIT;
            ALU_WAIT:    if (dwell_cnt == ALU_LAST)
                             state_nxt = WRITE_TRAMP;
            WRITE_TRAMP: state_nxt = WRITE;
            DONE:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
        if (to_hit)
            state_nxt = DONE;
        cnt_clr = ((state_nxt == PRESET) && (state_q != PRESET)) ||
                  ((state_q == WRITE_TRAMP) && (state_nxt == WRITE));
    end

    // State, counters and next-state-decoded registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            dwell_cnt      <= '0;
            req_strip_cnt  <= '0;
            resp_strip_cnt <= '0;
            app_en         <= 1'b0;
            app_wdf_wren   <= 1'b0;
            fifo_rd        <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if ((state_nxt != state_q) || (state_q == IDLE))
                dwell_cnt <= '0;
            else if (dwell_cnt != TO_LAST)
                dwell_cnt <= dwell_cnt + TW'(1);
            req_strip_cnt  <= cnt_clr ? '0 : req_strip_cnt + SW'(issue);
            resp_strip_cnt <= cnt_clr ? '0 : resp_post;
            app_en         <= (state_nxt == WRITE) || (state_nxt == READ_CMD);
            app_wdf_wren   <= (state_nxt == WRITE);
            fifo_rd        <= (state_nxt == DONE);
            timeout        <= to_hit;
        end
    end

endmodule

// File: tb/tb_mpmc12_req_sequencer.sv
// Bench for mpmc12_req_sequencer: directed scenarios with literal expectations
// plus a per-cycle reference model of the sequencing rules.
module tb_mpmc12_req_sequencer;
    localparam int MS = 8, AL = 4, PC = 3, TO = 16;
    localparam int SW = $clog2(MS) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic calib_complete = 0, rst_busy = 0, fifo_empty = 1, fifo_v = 0;
    logic req_cyc = 0, req_we = 0, req_rmw = 0;
    logic [SW-1:0] num_strips = '0;
    logic app_rdy = 0, app_wdf_rdy = 0, rd_data_valid = 0, rmw_hit = 0;
    logic [3:0] state;
    logic app_en, app_wdf_wren, fifo_rd, timeout, busy;
    logic [SW-1:0] req_strip_cnt, resp_strip_cnt;

    mpmc12_req_sequencer #(.MAX_STRIPS(MS), .ALU_LAT(AL), .PRESET_CYC(PC), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .calib_complete(calib_complete), .rst_busy(rst_busy),
        .fifo_empty(fifo_empty), .fifo_v(fifo_v), .req_cyc(req_cyc), .req_we(req_we),
        .req_rmw(req_rmw), .num_strips(num_strips), .app_rdy(app_rdy),
        .app_wdf_rdy(app_wdf_rdy), .rd_data_valid(rd_data_valid), .rmw_hit(rmw_hit),
        .state(state), .app_en(app_en), .app_wdf_wren(app_wdf_wren), .fifo_rd(fifo_rd),
        .req_strip_cnt(req_strip_cnt), .resp_strip_cnt(resp_strip_cnt),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: phase name, cycles spent in it, strips issued/returned
    int m_state = 0, m_dwell = 0, m_req = 0, m_resp = 0;
    bit m_en = 0, m_wren = 0, m_rd = 0, m_to = 0, started = 0;

    always @(posedge clk) begin
        int n, nxt, rp;
        bit iss, to, clr;
        started = 1;
        if (rst) begin
            m_state = 0; m_dwell = 0; m_req = 0; m_resp = 0;
            m_en = 0; m_wren = 0; m_rd = 0; m_to = 0;
        end else begin
            n   = (num_strips == 0) ? 1 : int'(num_strips);
            nxt = m_state;
            to  = 0;
            rp  = m_resp;
            if ((m_state == 3 || m_state == 4) && rd_data_valid && m_resp < n) rp = m_resp + 1;
            iss = (m_state == 2 && app_rdy && app_wdf_rdy) || (m_state == 3 && app_rdy);
            case (m_state)
                0: if (!fifo_empty && fifo_v && !rst_busy && calib_complete) nxt = 1;
                1: if (m_dwell + 1 == PC) nxt = !req_cyc ? 8 : (req_we ? 2 : 3);
                2: if (iss && m_req + 1 == n) nxt = 8;
                3: if (iss && m_req + 1 == n) nxt = (rp == n) ? (req_rmw ? 5 : 8) : 4;
                4: if (rp == n) nxt = req_rmw ? 5 : 8;
                5: if (rmw_hit) nxt = 6;
                6: if (m_dwell + 1 == AL) nxt = 7;
                7: nxt = 2;
                default: nxt = 0;
            endcase
            if (m_state != 0 && m_dwell + 1 >= TO && calib_complete) begin
                nxt = 8; to = 1;
            end
            clr = (nxt == 1 && m_state == 0) || (m_state == 7 && nxt == 2);
            m_req  = clr ? 0 : m_req + int'(iss);
            m_resp = clr ? 0 : rp;
            m_dwell = (nxt != m_state || nxt == 0) ? 0 : m_dwell + 1;
            m_state = nxt;
            m_en = (nxt == 2 || nxt == 3);
            m_wren = (nxt == 2);
            m_rd = (nxt == 8);
            m_to = to;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("state", int'(state), m_state);
            chk("app_en", int'(app_en), int'(m_en));
            chk("app_wdf_wren", int'(app_wdf_wren), int'(m_wren));
            chk("fifo_rd", int'(fifo_rd), int'(m_rd));
            chk("req_strip_cnt", int'(req_strip_cnt), m_req);
            chk("resp_strip_cnt", int'(resp_strip_cnt), m_resp);
            chk("timeout", int'(timeout), int'(m_to));
            chk("busy", int'(busy), int'(m_state != 0));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int tr[18];
    int e1[7]  = '{1, 1, 1, 3, 4, 8, 0};
    int e4[18] = '{1, 1, 1, 3, 3, 4, 5, 5, 5, 6, 6, 6, 6, 7, 2, 2, 8, 0};
    int hs, pulses, fin, a, b, c, d, e, tc;

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_state", int'(state), 0);
        chk("rst_outs", int'({app_en, app_wdf_wren, fifo_rd, timeout, busy}), 0);
        chk("rst_cnts", int'(req_strip_cnt) + int'(resp_strip_cnt), 0);
        rst = 0;

        // single-strip read, held off first by rst_busy
        tick();
        calib_complete = 1; rst_busy = 1; fifo_empty = 0; fifo_v = 1; req_cyc = 1;
        req_we = 0; req_rmw = 0; num_strips = 1; app_rdy = 1; app_wdf_rdy = 1;
        repeat (3) tick();
        chk("rst_busy_hold", int'(state), 0);
        rst_busy = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            tr[i] = int'(state);
            if (i == 5) a = int'(fifo_rd);
            rd_data_valid = (i == 4);
            if (i == 5) fifo_empty = 1;
        end
        for (int i = 0; i < 7; i++) chk($sformatf("rd1_trace[%0d]", i), tr[i], e1[i]);
        chk("rd1_fifo_rd", a, 1);

        // 4-strip write with app_wdf_rdy toggling
        tick();
        req_we = 1; num_strips = 4; fifo_empty = 0;
        hs = 0; pulses = 0; fin = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            app_wdf_rdy = (i % 2 == 1);
            if (app_en && app_wdf_wren && app_rdy && app_wdf_rdy) hs++;
            if (fifo_rd) begin pulses++; fin = int'(req_strip_cnt); fifo_empty = 1; end
        end
        chk("wr4_handshakes", hs, 4);
        chk("wr4_fifo_rd", pulses, 1);
        chk("wr4_final_cnt", fin, 4);

        // 8-strip read, early responses and surplus valids
        tick();
        req_we = 0; num_strips = 8; app_rdy = 1; app_wdf_rdy = 1; fifo_empty = 0;
        for (int i = 0; i < 21; i++) begin
            tick();
            if (i == 11) begin a = int'(resp_strip_cnt); tc = int'(req_strip_cnt); end
            if (i == 17) b = int'(state);
            if (i == 18) begin c = int'(state); d = int'(resp_strip_cnt); fifo_empty = 1; end
            if (i == 20) e = int'(resp_strip_cnt);
            rd_data_valid = (i == 4 || i == 6 || (i >= 12 && i <= 19));
        end
        rd_data_valid = 0;
        chk("rd8_early_resp", a, 2);
        chk("rd8_issued", tc, 8);
        chk("rd8_wait_before_8th", b, 4);
        chk("rd8_done", c, 8);
        chk("rd8_resp_done", d, 8);
        chk("rd8_resp_sat", e, 8);

        // 2-strip read, responses saturate before commands finish
        tick();
        num_strips = 2; app_rdy = 0; fifo_empty = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (i == 7) a = int'(resp_strip_cnt);
            if (i == 8) b = int'(state);
            if (i == 9) begin c = int'(state); fifo_empty = 1; end
            rd_data_valid = (i >= 3 && i <= 6);
            app_rdy = (i >= 7);
        end
        chk("rd2_resp_sat", a, 2);
        chk("rd2_still_cmd", b, 3);
        chk("rd2_direct_done", c, 8);

        // CAS read-modify-write, 2 strips
        tick();
        req_rmw = 1; num_strips = 2; app_rdy = 1; app_wdf_rdy = 1; fifo_empty = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            tr[i] = int'(state);
            if (i == 14) begin a = int'(req_strip_cnt); b = int'(resp_strip_cnt); end
            rd_data_valid = (i == 4 || i == 5);
            rmw_hit = (i == 8);
            if (i == 16) fifo_empty = 1;
        end
        for (int i = 0; i < 18; i++) chk($sformatf("rmw_trace[%0d]", i), tr[i], e4[i]);
        chk("rmw_req_clr", a, 0);
        chk("rmw_resp_clr", b, 0);
        req_rmw = 0;

        // READ_WAIT hang with calibration present
        tick();
        num_strips = 1; fifo_empty = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (i == 19) a = int'(state);
            if (i == 20) begin b = int'(state); c = int'(timeout); d = int'(fifo_rd); fifo_empty = 1; end
            if (i == 21) e = int'(timeout);
        end
        chk("to_wait16", a, 4);
        chk("to_done", b, 8);
        chk("to_pulse", c, 1);
        chk("to_fifo_rd", d, 1);
        chk("to_pulse_end", e, 0);

        // same hang with calibration lost: no abort
        tick();
        fifo_empty = 0;
        tc = 0;
        for (int i = 0; i < 41; i++) begin
            tick();
            calib_complete = 0;
            if (timeout) tc++;
            if (i == 38) a = int'(state);
            if (i == 39) begin b = int'(state); fifo_empty = 1; end
            rd_data_valid = (i == 38);
        end
        calib_complete = 1;
        chk("nocal_no_timeout", tc, 0);
        chk("nocal_still_wait", a, 4);
        chk("nocal_done", b, 8);

        // num_strips = 0 behaves as one strip
        tick();
        req_we = 1; num_strips = 0; fifo_empty = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 4) begin a = int'(req_strip_cnt); b = int'(fifo_rd); fifo_empty = 1; end
        end
        chk("zero_strips_cnt", a, 1);
        chk("zero_strips_done", b, 1);

        // reset mid-burst in WRITE
        tick();
        num_strips = 8; fifo_empty = 0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fifo_rd) pulses++;
            if (i == 4) a = int'(state);
            if (i == 6) begin
                b = int'(state);
                c = int'({app_en, app_wdf_wren, fifo_rd, timeout, busy});
                d = int'(req_strip_cnt);
                rst = 0;
            end
            if (i == 5) begin rst = 1; fifo_empty = 1; end
        end
        chk("rst_mid_was_write", a, 2);
        chk("rst_mid_idle", b, 0);
        chk("rst_mid_outs", c, 0);
        chk("rst_mid_cnt", d, 0);
        chk("rst_mid_no_pop", pulses, 0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
